task3_majority_voter: RTL and testbench

Three-input majority voter for the fundamental-electronics experiment set: output `d` is high when at least two of `a`, `b`, `c` are high. The vote is registered on a single clock domain and reports agreement status. Optional per-input dissent counters flag a voter that repeatedly disagrees with the majority. The block sits at the leaf level and drives board LEDs or a downstream checker directly.

---
 rtl/task3_pkg.sv | 17 +
 rtl/task3_sat_counter.sv | 35 +++
 rtl/task3_majority_voter.sv | 88 ++++++++
 tb/tb_task3_majority_voter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/task3_pkg.sv
// Shared constants and the majority function for the three-input voter.
package task3_pkg;

    // Default width of each dissent counter.
    localparam int TASK3_CNT_W = 8;

    // Bit positions of each voter inside the dissent vector {a,b,c}.
    localparam int IDX_A = 2;
    localparam int IDX_B = 1;
    localparam int IDX_C = 0;

    // Two-of-three majority.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (b & c) | (a & c);
    endfunction

endpackage

// File: rtl/task3_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module task3_sat_counter
    import task3_pkg::*;
#(
    parameter int W = TASK3_CNT_W
) (
    input  logic         clk,
    input  logic         clr_n_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: step by one on request unless already at the maximum.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register; clear wins over any increment.
    always_ff @(posedge clk) begin
        if (!clr_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/task3_majority_voter.sv
// Registered three-input majority voter with agreement and dissent reporting.
// Optional per-input saturating dissent counters exist only when the macro
// TASK3_DISSENT_CNT_EN is defined; without it the counter ports are absent.
module task3_majority_voter
    import task3_pkg::*;
#(
    parameter int CNT_W = TASK3_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             d,
    output logic             unanimous,
    output logic [2:0]       dissent
`ifdef TASK3_DISSENT_CNT_EN
    ,
    output logic [CNT_W-1:0] dissent_cnt_a,
    output logic [CNT_W-1:0] dissent_cnt_b,
    output logic [CNT_W-1:0] dissent_cnt_c
`endif
);

    // Reject a degenerate counter width at elaboration.
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic       d_q, d_d;
    logic       unanimous_q, unanimous_d;
    logic [2:0] dissent_q, dissent_d;

    // Majority, agreement and the odd-one-out marker from the current votes.
    // At most one dissent bit can be set: two dissenters would themselves
    // form the majority.
    always_comb begin
        d_d                = maj3(a, b, c);
        unanimous_d        = (a == b) && (b == c);
        dissent_d          = 3'b000;
        dissent_d[IDX_A]   = a ^ d_d;
        dissent_d[IDX_B]   = b ^ d_d;
        dissent_d[IDX_C]   = c ^ d_d;
    end

    // Output registers; reset clears everything and takes priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q         <= 1'b0;
            unanimous_q <= 1'b0;
            dissent_q   <= 3'b000;
        end else begin
            d_q         <= d_d;
            unanimous_q <= unanimous_d;
            dissent_q   <= dissent_d;
        end
    end

    assign d         = d_q;
    assign unanimous = unanimous_q;
    assign dissent   = dissent_q;

`ifdef TASK3_DISSENT_CNT_EN
    // Counters are fed the unregistered dissent so they update on the same
    // edge that loads the dissent register.
    task3_sat_counter #(.W(CNT_W)) u_cnt_a (
        .clk     (clk),
        .clr_n_i (rst_n),
        .inc_i   (dissent_d[IDX_A]),
        .cnt_o   (dissent_cnt_a)
    );

    task3_sat_counter #(.W(CNT_W)) u_cnt_b (
        .clk     (clk),
        .clr_n_i (rst_n),
        .inc_i   (dissent_d[IDX_B]),
        .cnt_o   (dissent_cnt_b)
    );

    task3_sat_counter #(.W(CNT_W)) u_cnt_c (
        .clk     (clk),
        .clr_n_i (rst_n),
        .inc_i   (dissent_d[IDX_C]),
        .cnt_o   (dissent_cnt_c)
    );
`endif

endmodule

// File: tb/tb_task3_majority_voter.sv
// Self-checking bench for task3_majority_voter. Counter checks are compiled
// in only when TASK3_DISSENT_CNT_EN is defined.
module tb_task3_majority_voter;

    localparam int CNT_W  = 2;
    localparam int EXP_W  = 5 + 3 * CNT_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             a, b, c;
    logic             d;
    logic             unanimous;
    logic [2:0]       dissent;
`ifdef TASK3_DISSENT_CNT_EN
    logic [CNT_W-1:0] cnt_a, cnt_b, cnt_c;
`endif

    int tests_run;
    int tests_failed;

    // Expected entries: {d, unanimous, dissent[2:0], cnt_a, cnt_b, cnt_c}.
    logic [EXP_W-1:0] exp_q[$];
    int               mdl_cnt[3];  // index 2 = A, 1 = B, 0 = C

    task3_majority_voter #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .a             (a),
        .b             (b),
        .c             (c),
        .d             (d),
        .unanimous     (unanimous),
        .dissent       (dissent)
`ifdef TASK3_DISSENT_CNT_EN
        ,
        .dissent_cnt_a (cnt_a),
        .dissent_cnt_b (cnt_b),
        .dissent_cnt_c (cnt_c)
`endif
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model built from the population count of the votes.
    function automatic logic [4:0] vote_model(input logic [2:0] abc);
        int         ones;
        logic       m, u;
        logic [2:0] dis;
        ones = $countones(abc);
        m    = (ones >= 2);
        u    = (ones == 0) || (ones == 3);
        if (ones == 1)      dis = abc;
        else if (ones == 2) dis = ~abc;
        else                dis = 3'b000;
        return {m, u, dis};
    endfunction

    function automatic logic [EXP_W-1:0] pack_exp(input logic [4:0] v);
        logic [CNT_W-1:0] ca, cb, cc;
        ca = CNT_W'(mdl_cnt[2]);
        cb = CNT_W'(mdl_cnt[1]);
        cc = CNT_W'(mdl_cnt[0]);
        return {v, ca, cb, cc};
    endfunction

    // Pop the oldest expectation and compare it with the registered outputs.
    task automatic compare_out(input string tag);
        logic [EXP_W-1:0] e;
        if (exp_q.size() == 0) begin
            check_eq({tag, " queue"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check_eq({tag, " d"},   {31'd0, d},         {31'd0, e[EXP_W-1]});
        check_eq({tag, " una"}, {31'd0, unanimous}, {31'd0, e[EXP_W-2]});
        check_eq({tag, " dis"}, {29'd0, dissent},   {29'd0, e[EXP_W-3 -: 3]});
`ifdef TASK3_DISSENT_CNT_EN
        check_eq({tag, " cnt_a"}, 32'(cnt_a), 32'(e[3*CNT_W-1 -: CNT_W]));
        check_eq({tag, " cnt_b"}, 32'(cnt_b), 32'(e[2*CNT_W-1 -: CNT_W]));
        check_eq({tag, " cnt_c"}, 32'(cnt_c), 32'(e[CNT_W-1 -: CNT_W]));
`endif
    endtask

    // Drive one vote, predict the result, and check it one edge later.
    task automatic apply_vote(input logic [2:0] abc, input string tag);
        logic [4:0] v;
        @(negedge clk);
        {a, b, c} = abc;
        rst_n     = 1'b1;
        v = vote_model(abc);
        for (int i = 0; i < 3; i++) begin
            if (v[i] && mdl_cnt[i] < CNT_MAX) mdl_cnt[i]++;
        end
        exp_q.push_back(pack_exp(v));
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    // Hold reset for one edge with non-trivial inputs present.
    task automatic apply_reset(input logic [2:0] abc, input string tag);
        @(negedge clk);
        {a, b, c} = abc;
        rst_n     = 1'b0;
        for (int i = 0; i < 3; i++) mdl_cnt[i] = 0;
        exp_q.push_back(pack_exp(5'b0));
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    // Directed and random stimulus, then the report.
    initial begin
        logic [2:0] abc;
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < 3; i++) mdl_cnt[i] = 0;
        rst_n = 1'b0;
        {a, b, c} = 3'b000;

        apply_reset(3'b111, "reset0");
        apply_reset(3'b011, "reset1");

        // Exhaustive sweep.
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            apply_vote(abc, $sformatf("sweep abc=%b", abc));
        end

        // Dissent encoding, including unanimous cases.
        apply_vote(3'b011, "dis 011");
        apply_vote(3'b101, "dis 101");
        apply_vote(3'b110, "dis 110");
        apply_vote(3'b000, "dis 000");
        apply_vote(3'b111, "dis 111");

        // Saturation of counter A from zero while B and C stay idle.
        apply_reset(3'b000, "sat clr");
        for (int i = 0; i < 6; i++) begin
            apply_vote(3'b011, $sformatf("sat %0d", i));
        end
        apply_vote(3'b101, "sat other b");
        apply_vote(3'b110, "sat other c");

        // Reset mid-run with counters non-zero, then release on 111.
        apply_reset(3'b110, "mid reset");
        apply_vote(3'b111, "release 111");

        // Random votes.
        for (int i = 0; i < 40; i++) begin
            abc = 3'($urandom_range(0, 7));
            apply_vote(abc, $sformatf("rand %0d abc=%b", i, abc));
        end

        check_eq("queue empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
